// File: rtl/as_rv32i_trap_ctrl.sv
// as_rv32i_trap_ctrl: machine-mode trap/return sequencer owning mstatus.MIE/MPIE, mepc, mcause and mtval
module as_rv32i_trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_ce,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_fault_addr,
  input  logic [31:0] i_instr,
  input  logic        i_exc_instr_misaligned,
  input  logic        i_exc_illegal,
  input  logic        i_exc_ebreak,
  input  logic        i_exc_ecall,
  input  logic        i_exc_load_misaligned,
  input  logic        i_exc_store_misaligned,
  input  logic        i_is_mret,
  input  logic        i_ext_irq,
  input  logic        i_timer_irq,
  input  logic        i_sw_irq,
  input  logic [2:0]  i_mie,
  input  logic [31:0] i_mtvec,
  input  logic        i_csr_wr,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic        o_go_to_trap,
  output logic        o_return_from_trap,
  output logic [31:0] o_trap_address,
  output logic [31:0] o_return_address,
  output logic        o_mstatus_mie,
  output logic        o_mstatus_mpie,
  output logic [31:0] o_mepc,
  output logic [31:0] o_mcause,
  output logic [31:0] o_mtval,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;
  state_t r_state;
  logic [3*IRQ_SYNC_STAGES-1:0] r_sync;
  logic [2:0]  w_irq, w_ip;
  logic        w_exc, w_int, w_eval, w_take, w_csr;
  logic [31:0] w_cause, w_mtval, w_base, w_vec, w_int_cause;

  // Shift register synchronising {ext,timer,sw}; the oldest stage feeds the prioritiser
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= '0;
    else r_sync <= {r_sync[3*IRQ_SYNC_STAGES-4:0], i_ext_irq, i_timer_irq, i_sw_irq};

  // Prioritise exceptions over interrupts and compute the captured cause, mtval and target
  always_comb begin
    w_irq = r_sync[3*IRQ_SYNC_STAGES-1 -: 3];
    w_ip = w_irq & i_mie;
    w_exc = i_exc_instr_misaligned | i_exc_illegal | i_exc_ebreak | i_exc_ecall |
            i_exc_load_misaligned | i_exc_store_misaligned;
    w_int = o_mstatus_mie & (|w_ip);
    w_eval = (r_state == IDLE) & i_valid & i_ce;
    w_take = w_eval & (w_exc | w_int);
    w_csr = (r_state == IDLE) & i_csr_wr & ~w_take;
    w_int_cause = w_ip[2] ? 32'h8000_000B : w_ip[0] ? 32'h8000_0003 : 32'h8000_0007;
    w_cause = i_exc_instr_misaligned ? 32'd0 : i_exc_illegal ? 32'd2 : i_exc_ebreak ? 32'd3 :
              i_exc_ecall ? 32'd11 : i_exc_load_misaligned ? 32'd4 :
              i_exc_store_misaligned ? 32'd6 : w_int_cause;
    w_mtval = (i_exc_instr_misaligned | (~i_exc_illegal & i_exc_ebreak)) ? i_pc :
              i_exc_illegal ? i_instr : i_exc_ecall ? 32'd0 :
              (i_exc_load_misaligned | i_exc_store_misaligned) ? i_fault_addr : 32'd0;
    w_base = {i_mtvec[31:2], 2'b00};
    w_vec = (i_mtvec[1:0] == 2'b01 && !w_exc) ? w_base + {25'd0, w_cause[4:0], 2'b00} : w_base;
  end

  // Trap sequencer: capture in IDLE, hold the handshake in TRAP/RET until the writeback enable
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      o_go_to_trap <= 1'b0;
      o_return_from_trap <= 1'b0;
      o_trap_address <= {RESET_MTVEC[31:2], 2'b00};
      o_mstatus_mie <= 1'b0;
      o_mstatus_mpie <= 1'b0;
      o_mepc <= '0;
      o_mcause <= '0;
      o_mtval <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_csr)
            case (i_csr_addr)
              12'h300: begin
                o_mstatus_mie <= i_csr_wdata[3];
                o_mstatus_mpie <= i_csr_wdata[7];
              end
              12'h341: o_mepc <= i_csr_wdata & ~32'd3;
              12'h342: o_mcause <= i_csr_wdata;
              12'h343: o_mtval <= i_csr_wdata;
              default: ;
            endcase
          if (w_take) begin
            r_state <= TRAP;
            o_go_to_trap <= 1'b1;
            o_mcause <= w_cause;
            o_mtval <= w_mtval;
            o_mepc <= i_pc;
            o_trap_address <= w_vec;
          end else if (w_eval && i_is_mret) begin
            r_state <= RET;
            o_return_from_trap <= 1'b1;
          end
        end
        TRAP:
          if (i_ce) begin
            r_state <= IDLE;
            o_go_to_trap <= 1'b0;
            o_mstatus_mpie <= o_mstatus_mie;
            o_mstatus_mie <= 1'b0;
          end
        RET:
          if (i_ce) begin
            r_state <= IDLE;
            o_return_from_trap <= 1'b0;
            o_mstatus_mie <= o_mstatus_mpie;
            o_mstatus_mpie <= 1'b1;
          end
        default: r_state <= IDLE;
      endcase
    end

  assign o_return_address = o_mepc;
  assign o_busy = r_state != IDLE;
endmodule

// File: tb/tb_as_rv32i_trap_ctrl.sv
// tb_as_rv32i_trap_ctrl: directed self-checking bench for the trap sequencer
module tb_as_rv32i_trap_ctrl;
  localparam logic [31:0] RMTVEC = 32'h0000_1000;
  logic clk = 0, rst_n = 0;
  logic valid = 0, ce = 0;
  logic [31:0] pc = 0, fault_addr = 0, instr = 0, mtvec = 0, csr_wdata = 0;
  logic e_imis = 0, e_ill = 0, e_ebrk = 0, e_ecall = 0, e_lmis = 0, e_smis = 0, mret = 0;
  logic ext = 0, tmr = 0, sw = 0, csr_wr = 0;
  logic [2:0] mie_en = 0;
  logic [11:0] csr_addr = 0;
  logic go, ret, m_mie, m_mpie, busy;
  logic [31:0] taddr, raddr, mepc, mcause, mtval;
  int n_chk = 0, n_err = 0;

  as_rv32i_trap_ctrl #(.RESET_MTVEC(RMTVEC), .IRQ_SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ce(ce), .i_pc(pc),
    .i_fault_addr(fault_addr), .i_instr(instr),
    .i_exc_instr_misaligned(e_imis), .i_exc_illegal(e_ill), .i_exc_ebreak(e_ebrk),
    .i_exc_ecall(e_ecall), .i_exc_load_misaligned(e_lmis), .i_exc_store_misaligned(e_smis),
    .i_is_mret(mret), .i_ext_irq(ext), .i_timer_irq(tmr), .i_sw_irq(sw), .i_mie(mie_en),
    .i_mtvec(mtvec), .i_csr_wr(csr_wr), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
    .o_go_to_trap(go), .o_return_from_trap(ret), .o_trap_address(taddr),
    .o_return_address(raddr), .o_mstatus_mie(m_mie), .o_mstatus_mpie(m_mpie),
    .o_mepc(mepc), .o_mcause(mcause), .o_mtval(mtval), .o_busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [11:0] a, input logic [31:0] d);
    csr_wr = 1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wr = 0;
  endtask

  initial begin
    tick(); tick();
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_taddr", taddr, RMTVEC);
    check("rst_mcause", mcause, 0);
    rst_n = 1;
    tick();
    csr(12'h300, 32'h8);
    check("csr_mie", {m_mpie, m_mie}, 2'b01);
    csr(12'h342, 32'hDEAD);
    check("csr_mcause", mcause, 32'hDEAD);
    csr(12'h343, 32'hBEEF);
    check("csr_mtval", mtval, 32'hBEEF);
    // ecall
    valid = 1; ce = 1; e_ecall = 1; pc = 32'h100; mtvec = 32'h200;
    tick();
    valid = 0; ce = 0; e_ecall = 0;
    check("ecall_go", go, 1);
    check("ecall_busy", busy, 1);
    check("ecall_taddr", taddr, 32'h200);
    check("ecall_mcause", mcause, 11);
    check("ecall_mepc", mepc, 32'h100);
    check("ecall_mtval", mtval, 0);
    check("ecall_mie_hold", {m_mpie, m_mie}, 2'b01);
    ce = 1;
    tick();
    check("ecall_hs_go", go, 0);
    check("ecall_hs_mstatus", {m_mpie, m_mie}, 2'b10);
    check("ecall_hs_busy", busy, 0);
    // timer interrupt, vectored, with a stalled handshake
    csr(12'h300, 32'h88);
    mie_en = 3'b010; mtvec = 32'h201; pc = 32'h500; valid = 1; ce = 1; tmr = 1;
    tick();
    check("tmr_lat1", go, 0);
    tick();
    check("tmr_lat2", go, 0);
    tick();
    ce = 0; valid = 0; tmr = 0;
    check("tmr_go", go, 1);
    check("tmr_taddr", taddr, 32'h21C);
    check("tmr_mcause", mcause, 32'h8000_0007);
    check("tmr_mepc", mepc, 32'h500);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_go", go, 1);
      check("stall_mstatus", {m_mpie, m_mie}, 2'b11);
    end
    ce = 1;
    tick();
    check("tmr_hs_go", go, 0);
    check("tmr_hs_mstatus", {m_mpie, m_mie}, 2'b10);
    // illegal + load misaligned + ext irq: illegal wins
    csr(12'h300, 32'h88);
    mie_en = 3'b111; ext = 1;
    tick(); tick(); tick();
    valid = 1; e_ill = 1; e_lmis = 1; pc = 32'h40; instr = 32'hFFFF_FFFF; fault_addr = 32'h1234;
    tick();
    valid = 0; e_ill = 0; e_lmis = 0; ext = 0;
    check("ill_go", go, 1);
    check("ill_mcause", mcause, 2);
    check("ill_mtval", mtval, 32'hFFFF_FFFF);
    check("ill_taddr", taddr, 32'h200);
    check("ill_mepc", mepc, 32'h40);
    tick();
    check("ill_hs_go", go, 0);
    // mret
    csr(12'h341, 32'h303);
    check("mepc_wr", mepc, 32'h300);
    check("mret_pre", {m_mpie, m_mie}, 2'b10);
    valid = 1; mret = 1;
    tick();
    valid = 0; mret = 0; ce = 0;
    check("mret_ret", ret, 1);
    check("mret_raddr", raddr, 32'h300);
    check("mret_busy", busy, 1);
    tick();
    check("mret_hold", ret, 1);
    ce = 1;
    tick();
    check("mret_hs_ret", ret, 0);
    check("mret_hs_mstatus", {m_mpie, m_mie}, 2'b11);
    // store misaligned then asynchronous reset mid-handshake
    valid = 1; e_smis = 1; pc = 32'h600; fault_addr = 32'hABC;
    tick();
    valid = 0; e_smis = 0; ce = 0;
    check("st_mcause", mcause, 6);
    check("st_mtval", mtval, 32'hABC);
    check("st_go", go, 1);
    #2 rst_n = 0;
    #1;
    check("arst_go", go, 0);
    check("arst_busy", busy, 0);
    check("arst_taddr", taddr, RMTVEC);
    check("arst_mie", m_mie, 0);
    rst_n = 1;
    tick();
    check("post_rst_go", go, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
